// File: rtl/vga_stream_monitor.sv
// Passive VGA bus tap: recovers pixel coordinates, verifies raster timing, and publishes a per-frame checksum.
// Define VGA_MON_CRC_EN to replace the additive checksum with CRC-16-CCITT over each pixel's {R,G,B}.
module vga_stream_monitor #(
   parameter int H_ACTIVE    = 640,
   parameter int V_ACTIVE    = 480,
   parameter int H_TOTAL     = 800,
   parameter int V_TOTAL     = 525,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clk,
   input  logic        resetN,
   input  logic        vga_clk,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic        vga_blank_n,
   input  logic [7:0]  vga_r,
   input  logic [7:0]  vga_g,
   input  logic [7:0]  vga_b,
   output logic [10:0] pixelX,
   output logic [10:0] pixelY,
   output logic        pixel_valid,
   output logic [23:0] rgb_out,
   output logic        startOfFrame,
   output logic        locked,
   output logic        line_error,
   output logic        frame_error,
   output logic [15:0] frame_checksum,
   output logic        checksum_valid,
   output logic [7:0]  frame_count
);

   localparam logic [10:0] C_HTOTAL = 11'(H_TOTAL);
   localparam logic [10:0] C_VTOTAL = 11'(V_TOTAL);
   localparam logic [3:0]  C_LOCK   = 4'(LOCK_FRAMES);
   localparam logic [10:0] C_SAT    = 11'd2047;
`ifdef VGA_MON_CRC_EN
   localparam logic [15:0] C_SUM_INIT = 16'hFFFF;
`else
   localparam logic [15:0] C_SUM_INIT = 16'h0000;
`endif

   if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL || LOCK_FRAMES < 1 || LOCK_FRAMES > 15) begin : g_paramCheck
      $error("vga_stream_monitor: inconsistent raster or lock parameters");
   end

   typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_t;

   function automatic logic [15:0] sumStep(input logic [15:0] acc, input logic [23:0] rgb);
      logic [15:0] c;
`ifdef VGA_MON_CRC_EN
      c = acc;
      for (int i = 23; i >= 0; i--) begin
         if (c[15] ^ rgb[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else                c = {c[14:0], 1'b0};
      end
`else
      c = acc + {rgb[23:16] ^ rgb[7:0], rgb[15:8]};
`endif
      return c;
   endfunction

   logic        r_clkS, r_clkPrev, r_hsS, r_vsS, r_blankS;
   logic [23:0] r_rgbS;
   logic        r_hsPrev, r_vsPrev, r_blankPrev;
   logic [10:0] r_hcnt, r_vcnt, r_xCnt, r_yCnt;
   logic        r_lineBad;
   logic [15:0] r_sum;
   state_t      r_state, w_stateNext;
   logic [3:0]  r_goodCnt, w_goodNext;
   logic        w_lineErr, w_frameErr, w_publish, w_lockSet, w_lockClr;

   logic        w_pixEn, w_hsFall, w_vsFall, w_blankRise, w_blankFall, w_visible;
   logic        w_lineMis, w_lineBadNow, w_frameGood;
   logic [10:0] w_vcntNow, w_xNow;

   assign w_pixEn      = r_clkS & ~r_clkPrev;
   assign w_hsFall     = w_pixEn & r_hsPrev & ~r_hsS;
   assign w_vsFall     = w_pixEn & r_vsPrev & ~r_vsS;
   assign w_blankRise  = w_pixEn & ~r_blankPrev & r_blankS;
   assign w_blankFall  = w_pixEn & r_blankPrev & ~r_blankS;
   assign w_visible    = w_pixEn & r_blankS;
   assign w_lineMis    = w_hsFall & (r_hcnt != C_HTOTAL);
   assign w_lineBadNow = r_lineBad | w_lineMis;
   // A coincident HS fall closes the last line of the frame, so it is counted before the frame check.
   assign w_vcntNow    = r_vcnt + {10'd0, w_hsFall};
   assign w_frameGood  = (w_vcntNow == C_VTOTAL) & ~w_lineBadNow;
   assign w_xNow       = w_blankRise ? 11'd0 : r_xCnt;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_clkS      <= 1'b0;
         r_clkPrev   <= 1'b0;
         r_hsS       <= 1'b0;
         r_vsS       <= 1'b0;
         r_blankS    <= 1'b0;
         r_rgbS      <= '0;
         r_hsPrev    <= 1'b0;
         r_vsPrev    <= 1'b0;
         r_blankPrev <= 1'b0;
      end else begin
         r_clkS    <= vga_clk;
         r_clkPrev <= r_clkS;
         r_hsS     <= vga_hs;
         r_vsS     <= vga_vs;
         r_blankS  <= vga_blank_n;
         r_rgbS    <= {vga_r, vga_g, vga_b};
         if (w_pixEn) begin
            r_hsPrev    <= r_hsS;
            r_vsPrev    <= r_vsS;
            r_blankPrev <= r_blankS;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_hcnt    <= '0;
         r_vcnt    <= '0;
         r_lineBad <= 1'b0;
         r_xCnt    <= '0;
         r_yCnt    <= '0;
         r_sum     <= C_SUM_INIT;
      end else begin
         if (w_hsFall)                        r_hcnt <= 11'd1;
         else if (w_pixEn && r_hcnt != C_SAT) r_hcnt <= r_hcnt + 11'd1;
         if (w_vsFall)                         r_vcnt <= '0;
         else if (w_hsFall && r_vcnt != C_SAT) r_vcnt <= r_vcnt + 11'd1;
         if (w_vsFall)       r_lineBad <= 1'b0;
         else if (w_lineMis) r_lineBad <= 1'b1;
         if (w_visible) r_xCnt <= (w_xNow == C_SAT) ? C_SAT : w_xNow + 11'd1;
         if (w_vsFall)                            r_yCnt <= '0;
         else if (w_blankFall && r_yCnt != C_SAT) r_yCnt <= r_yCnt + 11'd1;
         if (w_vsFall)       r_sum <= C_SUM_INIT;
         else if (w_visible) r_sum <= sumStep(r_sum, r_rgbS);
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state   <= UNLOCKED;
         r_goodCnt <= '0;
      end else begin
         r_state   <= w_stateNext;
         r_goodCnt <= w_goodNext;
      end
   end

   // A line fault while locked wins over a same-cycle frame check; the lost frame then scores as bad.
   always_comb begin
      w_stateNext = r_state;
      w_goodNext  = r_goodCnt;
      w_lineErr   = 1'b0;
      w_frameErr  = 1'b0;
      w_publish   = 1'b0;
      w_lockSet   = 1'b0;
      w_lockClr   = 1'b0;
      case (r_state)
         UNLOCKED: begin
            if (w_vsFall) begin
               w_stateNext = MEASURE;
               w_goodNext  = '0;
            end
         end
         MEASURE: begin
            if (w_vsFall) begin
               if (w_frameGood) begin
                  if (r_goodCnt + 4'd1 >= C_LOCK) begin
                     w_stateNext = LOCKED;
                     w_goodNext  = '0;
                     w_lockSet   = 1'b1;
                  end else begin
                     w_goodNext = r_goodCnt + 4'd1;
                  end
               end else begin
                  w_goodNext = '0;
               end
            end
         end
         LOCKED: begin
            if (w_lineMis) begin
               w_lineErr   = 1'b1;
               w_stateNext = MEASURE;
               w_goodNext  = '0;
               w_lockClr   = 1'b1;
            end else if (w_vsFall) begin
               if (w_vcntNow != C_VTOTAL) begin
                  w_frameErr  = 1'b1;
                  w_stateNext = MEASURE;
                  w_goodNext  = '0;
                  w_lockClr   = 1'b1;
               end else begin
                  w_publish = 1'b1;
               end
            end
         end
         default: w_stateNext = UNLOCKED;
      endcase
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pixelX         <= '0;
         pixelY         <= '0;
         pixel_valid    <= 1'b0;
         rgb_out        <= '0;
         startOfFrame   <= 1'b0;
         locked         <= 1'b0;
         line_error     <= 1'b0;
         frame_error    <= 1'b0;
         frame_checksum <= '0;
         checksum_valid <= 1'b0;
         frame_count    <= '0;
      end else begin
         pixel_valid    <= w_visible;
         startOfFrame   <= w_vsFall;
         line_error     <= w_lineErr;
         frame_error    <= w_frameErr;
         checksum_valid <= w_publish;
         if (w_visible) begin
            pixelX  <= w_xNow;
            pixelY  <= r_yCnt;
            rgb_out <= r_rgbS;
         end
         if (w_lockSet)      locked <= 1'b1;
         else if (w_lockClr) locked <= 1'b0;
         if (w_lockSet)      frame_count <= '0;
         else if (w_publish) frame_count <= frame_count + 8'd1;
         if (w_publish) frame_checksum <= r_sum;
      end
   end

endmodule

// File: tb/tb_vga_stream_monitor.sv
// Directed bench for vga_stream_monitor on a 12x6 raster (8x4 visible), two clk per pixel.
module tb_vga_stream_monitor;

   localparam int HA = 8;
   localparam int VA = 4;
   localparam int HT = 12;
   localparam int VT = 6;
   localparam int LF = 2;

`ifndef VGA_MON_CRC_EN
   localparam logic [15:0] EXP_CONST   = 16'h4040;
   localparam logic [15:0] EXP_PATTERN = 16'h7030;
   localparam logic [15:0] EXP_WRAP    = 16'hFFE0;
`endif

   logic        clk = 1'b0;
   logic        resetN = 1'b0;
   logic        vga_clk = 1'b0;
   logic        vga_hs = 1'b1;
   logic        vga_vs = 1'b1;
   logic        vga_blank_n = 1'b0;
   logic [7:0]  vga_r = 8'h00;
   logic [7:0]  vga_g = 8'h00;
   logic [7:0]  vga_b = 8'h00;
   logic [10:0] pixelX, pixelY;
   logic        pixel_valid, startOfFrame, locked, line_error, frame_error, checksum_valid;
   logic [23:0] rgb_out;
   logic [15:0] frame_checksum;
   logic [7:0]  frame_count;
   logic [75:0] w_allOut;

   int testsRun = 0;
   int failCount = 0;

   int pvFrame = 0, pvTotal = 0, sofCount = 0, lineErrCount = 0, frameErrCount = 0, ckvCount = 0, lockRiseSof = 0;
   int pvBefore;
   logic [10:0] firstX = '0, firstY = '0, lastX = '0, lastY = '0;
   logic [23:0] firstRgb = '0, lastRgb = '0;
   logic        prevLocked = 1'b0;

   vga_stream_monitor #(
      .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), .resetN(resetN), .vga_clk(vga_clk), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
      .pixelX(pixelX), .pixelY(pixelY), .pixel_valid(pixel_valid), .rgb_out(rgb_out),
      .startOfFrame(startOfFrame), .locked(locked), .line_error(line_error),
      .frame_error(frame_error), .frame_checksum(frame_checksum),
      .checksum_valid(checksum_valid), .frame_count(frame_count)
   );

   assign w_allOut = {pixelX, pixelY, pixel_valid, rgb_out, startOfFrame, locked, line_error,
                      frame_error, frame_checksum, checksum_valid, frame_count};

   always #10 clk = ~clk;

   // Event log sampled on the falling clk edge, between the DUT's register updates.
   always @(negedge clk) begin
      prevLocked <= locked;
      if (startOfFrame) begin
         sofCount <= sofCount + 1;
         pvFrame  <= 0;
      end
      if (pixel_valid) begin
         pvTotal <= pvTotal + 1;
         pvFrame <= pvFrame + 1;
         if (pvFrame == 0) begin
            firstX   <= pixelX;
            firstY   <= pixelY;
            firstRgb <= rgb_out;
         end
         lastX   <= pixelX;
         lastY   <= pixelY;
         lastRgb <= rgb_out;
      end
      if (line_error)     lineErrCount  <= lineErrCount + 1;
      if (frame_error)    frameErrCount <= frameErrCount + 1;
      if (checksum_valid) ckvCount      <= ckvCount + 1;
      if (locked && !prevLocked) lockRiseSof <= sofCount + (startOfFrame ? 1 : 0);
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

`ifdef VGA_MON_CRC_EN
   function automatic logic [15:0] tbCrc(input logic pattern, input logic [7:0] r, g, b);
      logic [15:0] c;
      logic [23:0] d;
      logic        fb;
      c = 16'hFFFF;
      for (int y = 0; y < VA; y++) begin
         for (int x = 0; x < HA; x++) begin
            d = pattern ? {8'(x), 8'(y), b} : {r, g, b};
            for (int i = 23; i >= 0; i--) begin
               fb = c[15] ^ d[i];
               c  = {c[14:0], 1'b0};
               if (fb) c = c ^ 16'h1021;
            end
         end
      end
      return c;
   endfunction
   logic [15:0] EXP_CONST, EXP_PATTERN, EXP_WRAP;
   initial begin
      EXP_CONST   = tbCrc(1'b0, 8'h01, 8'h02, 8'h03);
      EXP_PATTERN = tbCrc(1'b1, 8'h00, 8'h00, 8'hA0);
      EXP_WRAP    = tbCrc(1'b0, 8'hFF, 8'hFF, 8'h00);
   end
`endif

   task automatic checkOutput(input string tag, input logic [79:0] observed, input logic [79:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic drivePixel(input logic hs, input logic vs, input logic blank,
                             input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      @(negedge clk);
      vga_clk     = 1'b0;
      vga_hs      = hs;
      vga_vs      = vs;
      vga_blank_n = blank;
      vga_r       = r;
      vga_g       = g;
      vga_b       = b;
      @(negedge clk);
      vga_clk = 1'b1;
   endtask

   // One frame: line 0 carries VS, lines 2.. are visible, pixels 0-1 are HS, 3..10 visible.
   task automatic applyStimulus(input int nLines, input int shortLine, input logic pattern,
                                input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                                input int rstLine);
      int          lineLen;
      logic        act;
      logic [7:0]  pr, pg;
      for (int l = 0; l < nLines; l++) begin
         lineLen = (l == shortLine) ? HT - 1 : HT;
         for (int p = 0; p < lineLen; p++) begin
            if (l == rstLine && p == 5) begin
               checkOutput("preResetLocked", 80'(locked), 80'(1));
               @(negedge clk);
               resetN = 1'b0;
               #1;
               checkOutput("midResetOutputs", 80'(w_allOut), 80'(0));
               @(negedge clk);
               resetN = 1'b1;
            end
            act = (l >= 2) && (p >= 3) && (p < 3 + HA);
            pr  = pattern ? 8'(p - 3) : r;
            pg  = pattern ? 8'(l - 2) : g;
            drivePixel(p >= 2, l != 0, act, act ? pr : 8'h00, act ? pg : 8'h00, act ? b : 8'h00);
         end
      end
   endtask

   task automatic settle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #1;
      checkOutput("resetOutputs", 80'(w_allOut), 80'(0));
      @(negedge clk);
      resetN = 1'b1;
      repeat (4) drivePixel(1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      settle();
      checkOutput("idleOutputs", 80'(w_allOut), 80'(0));

      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("sofFirst", 80'(sofCount), 80'(1));
      checkOutput("lockedAfterVs1", 80'(locked), 80'(0));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("lockedAfterVs2", 80'(locked), 80'(0));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("lockedAfterVs3", 80'(locked), 80'(1));
      checkOutput("lockRiseAtVs3", 80'(lockRiseSof), 80'(3));
      checkOutput("noCkvOnLockFrame", 80'(ckvCount), 80'(0));
      checkOutput("frameCountAtLock", 80'(frame_count), 80'(0));

      applyStimulus(VT, -1, 1'b1, 8'h00, 8'h00, 8'hA0, -1);
      settle();
      checkOutput("firstCkv", 80'(ckvCount), 80'(1));
      checkOutput("frameCountOne", 80'(frame_count), 80'(1));
      checkOutput("checksumConst", 80'(frame_checksum), 80'(EXP_CONST));
      checkOutput("pixelsPerFrame", 80'(pvFrame), 80'(HA * VA));
      checkOutput("firstX", 80'(firstX), 80'(0));
      checkOutput("firstY", 80'(firstY), 80'(0));
      checkOutput("firstRgb", 80'(firstRgb), 80'(24'h0000A0));
      checkOutput("lastX", 80'(lastX), 80'(HA - 1));
      checkOutput("lastY", 80'(lastY), 80'(VA - 1));
      checkOutput("lastRgb", 80'(lastRgb), 80'(24'h0703A0));

      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("checksumPattern", 80'(frame_checksum), 80'(EXP_PATTERN));
      checkOutput("frameCountTwo", 80'(frame_count), 80'(2));

      applyStimulus(VT, 3, 1'b0, 8'h10, 8'h20, 8'h30, -1);
      settle();
      checkOutput("checksumConst2", 80'(frame_checksum), 80'(EXP_CONST));
      checkOutput("frameCountThree", 80'(frame_count), 80'(3));
      checkOutput("lineErrorOnce", 80'(lineErrCount), 80'(1));
      checkOutput("unlockedOnLineErr", 80'(locked), 80'(0));
      checkOutput("ckvBeforeBadFrame", 80'(ckvCount), 80'(3));

      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("noCkvBadLineFrame", 80'(ckvCount), 80'(3));
      checkOutput("lineErrorStillOnce", 80'(lineErrCount), 80'(1));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("notYetRelocked", 80'(locked), 80'(0));
      applyStimulus(VT, -1, 1'b0, 8'hFF, 8'hFF, 8'h00, -1);
      settle();
      checkOutput("relocked", 80'(locked), 80'(1));
      checkOutput("relockAtVs9", 80'(lockRiseSof), 80'(9));
      checkOutput("frameCountCleared", 80'(frame_count), 80'(0));

      applyStimulus(VT - 1, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("ckvAfterRelock", 80'(ckvCount), 80'(4));
      checkOutput("checksumWrap", 80'(frame_checksum), 80'(EXP_WRAP));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("frameErrorOnce", 80'(frameErrCount), 80'(1));
      checkOutput("unlockedOnFrameErr", 80'(locked), 80'(0));
      checkOutput("noCkvShortFrame", 80'(ckvCount), 80'(4));

      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("lockedBeforeReset", 80'(locked), 80'(1));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, 3);
      settle();
      checkOutput("unlockedAfterReset", 80'(locked), 80'(0));
      checkOutput("ckvBeforeReset", 80'(ckvCount), 80'(5));
      checkOutput("noLineErrUnlocked", 80'(lineErrCount), 80'(1));

      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("sofAfterReset", 80'(sofCount), 80'(15));
      checkOutput("lockedAfterResetVs1", 80'(locked), 80'(0));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("lockedAfterResetVs2", 80'(locked), 80'(0));
      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("lockedAfterResetVs3", 80'(locked), 80'(1));
      checkOutput("relockAtVs17", 80'(lockRiseSof), 80'(17));

      pvBefore = pvTotal;
      vga_blank_n = 1'b1;
      repeat (40) @(negedge clk);
      vga_blank_n = 1'b0;
      settle();
      checkOutput("stuckNoPixels", 80'(pvTotal), 80'(pvBefore));
      checkOutput("stuckHoldsLock", 80'(locked), 80'(1));

      applyStimulus(VT, -1, 1'b0, 8'h01, 8'h02, 8'h03, -1);
      settle();
      checkOutput("ckvAfterStuck", 80'(ckvCount), 80'(6));
      checkOutput("checksumAfterStuck", 80'(frame_checksum), 80'(EXP_CONST));
      checkOutput("frameCountAfterStuck", 80'(frame_count), 80'(1));
      checkOutput("frameErrorTotal", 80'(frameErrCount), 80'(1));

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
